forward_hazard_ctrl: RTL and testbench

- Control-side counterpart of the 3-input operand-select muxes in front of the ALU.
- Tracks the destination register of every instruction in the EX, MEM and WB stages.
- Drives the 2-bit select for the A and B operand muxes and raises a load-use stall that holds IF/ID and injects a bubble into EX.
- Counts stall cycles for performance debug.

---
 rtl/forward_hazard_ctrl_if.sv | 15 +
 rtl/forward_hazard_ctrl.sv | 60 ++++++
 tb/tb_forward_hazard_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/forward_hazard_ctrl_if.sv
// forward_hazard_ctrl_if: ID-stage operand info in, forwarding selects and load-use stall out
interface forward_hazard_ctrl_if #(parameter int REG_ADDR_W = 5, parameter int CNT_W = 16);
  logic id_valid, id_uses_rt, id_reg_write, id_mem_read, flush, stall;
  logic [REG_ADDR_W-1:0] id_rs, id_rt, id_dest;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [CNT_W-1:0] stall_count;
  modport master (
    output id_valid, id_rs, id_rt, id_uses_rt, id_reg_write, id_mem_read, id_dest, flush,
    input fwd_a_sel, fwd_b_sel, stall, stall_count
  );
  modport slave (
    input id_valid, id_rs, id_rt, id_uses_rt, id_reg_write, id_mem_read, id_dest, flush,
    output fwd_a_sel, fwd_b_sel, stall, stall_count
  );
endinterface

// File: rtl/forward_hazard_ctrl.sv
// forward_hazard_ctrl: ALU operand forwarding selects and load-use stall from EX/MEM/WB records
module forward_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  forward_hazard_ctrl_if.slave bus
);
  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic [REG_ADDR_W-1:0] dest;
  } rec_t;
  rec_t ex, mem, wb;
  logic [REG_ADDR_W-1:0] ex_rs, ex_rt;
  logic ex_uses_rt;
  logic [CNT_W-1:0] cnt;
  logic load_hit;
  function automatic logic writes(rec_t r, logic [REG_ADDR_W-1:0] a);
    return r.valid && r.reg_write && r.dest != '0 && r.dest == a;
  endfunction
  // MEM is checked before WB so the newest producer wins
  always_comb begin
    load_hit = ex.valid && ex.mem_read && ex.dest != '0 &&
               (ex.dest == bus.id_rs || (bus.id_uses_rt && ex.dest == bus.id_rt));
    bus.stall = bus.id_valid && !bus.flush && load_hit;
    bus.fwd_a_sel = !ex.valid ? 2'd0 : writes(mem, ex_rs) ? 2'd1 : writes(wb, ex_rs) ? 2'd2 : 2'd0;
    bus.fwd_b_sel = !(ex.valid && ex_uses_rt) ? 2'd0 : writes(mem, ex_rt) ? 2'd1 :
                    writes(wb, ex_rt) ? 2'd2 : 2'd0;
  end
  assign bus.stall_count = cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex <= '0;
      mem <= '0;
      wb <= '0;
      ex_rs <= '0;
      ex_rt <= '0;
      ex_uses_rt <= 1'b0;
      cnt <= '0;
    end else begin
      wb <= mem;
      mem <= ex;
      if (!bus.stall && !bus.flush) begin
        ex <= '{valid: bus.id_valid, reg_write: bus.id_reg_write, mem_read: bus.id_mem_read, dest: bus.id_dest};
        ex_rs <= bus.id_rs;
        ex_rt <= bus.id_rt;
        ex_uses_rt <= bus.id_uses_rt;
      end else begin
        ex <= '0;
        ex_rs <= '0;
        ex_rt <= '0;
        ex_uses_rt <= 1'b0;
      end
      if (bus.stall && cnt != '1) cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_forward_hazard_ctrl.sv
// tb_forward_hazard_ctrl: directed vector table, corner sequences and randomized model checking
module tb_forward_hazard_ctrl;
  logic clk, rst;
  forward_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(16)) bus ();
  forward_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(2)) bus2 ();
  forward_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(16)) dut (.clk(clk), .reset(rst), .bus(bus));
  forward_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(2)) dut2 (.clk(clk), .reset(rst), .bus(bus2));
  assign bus2.id_valid = bus.id_valid;
  assign bus2.id_rs = bus.id_rs;
  assign bus2.id_rt = bus.id_rt;
  assign bus2.id_uses_rt = bus.id_uses_rt;
  assign bus2.id_reg_write = bus.id_reg_write;
  assign bus2.id_mem_read = bus.id_mem_read;
  assign bus2.id_dest = bus.id_dest;
  assign bus2.flush = bus.flush;

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct {bit v, rw, mr, ut; int rs, rt, d;} ins_t;
  typedef struct {ins_t i; bit fl; int ea, eb, es, ec;} vec_t;

  int checks = 0, failures = 0;
  ins_t pipe[3];
  ins_t cur;
  bit cur_fl;
  int cnt16, cnt2;
  vec_t tbl[$];

  function automatic ins_t I(bit v, int rs, int rt, bit ut, bit rw, bit mr, int d);
    ins_t x;
    x.v = v; x.rs = rs; x.rt = rt; x.ut = ut; x.rw = rw; x.mr = mr; x.d = d;
    return x;
  endfunction

  function automatic vec_t V(ins_t i, bit fl, int ea, int eb, int es, int ec);
    vec_t x;
    x.i = i; x.fl = fl; x.ea = ea; x.eb = eb; x.es = es; x.ec = ec;
    return x;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", n, act, exp, $time);
    end
  endtask

  function automatic bit m_writes(ins_t s, int r);
    return s.v && s.rw && s.d != 0 && s.d == r;
  endfunction

  // youngest older producer of r among MEM (1) and WB (2)
  function automatic int m_sel(int r, bit used);
    if (!pipe[0].v || !used) return 0;
    for (int k = 1; k <= 2; k++) if (m_writes(pipe[k], r)) return k;
    return 0;
  endfunction

  function automatic bit m_stall();
    bit dep;
    dep = pipe[0].d == cur.rs || (cur.ut && pipe[0].d == cur.rt);
    return cur.v && !cur_fl && pipe[0].v && pipe[0].mr && pipe[0].d != 0 && dep;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 3; k++) pipe[k] = I(0, 0, 0, 0, 0, 0, 0);
    cnt16 = 0;
    cnt2 = 0;
  endtask

  task automatic drive(ins_t i, bit fl);
    cur = i;
    cur_fl = fl;
    bus.id_valid = i.v;
    bus.id_rs = 5'(i.rs);
    bus.id_rt = 5'(i.rt);
    bus.id_uses_rt = i.ut;
    bus.id_reg_write = i.rw;
    bus.id_mem_read = i.mr;
    bus.id_dest = 5'(i.d);
    bus.flush = fl;
    #4;
  endtask

  task automatic check_model();
    chk("model_fwd_a", 32'(bus.fwd_a_sel), 32'(m_sel(pipe[0].rs, 1'b1)));
    chk("model_fwd_b", 32'(bus.fwd_b_sel), 32'(m_sel(pipe[0].rt, pipe[0].ut)));
    chk("model_stall", 32'(bus.stall), 32'(m_stall()));
    chk("model_cnt16", 32'(bus.stall_count), 32'(cnt16));
    chk("model_cnt2", 32'(bus2.stall_count), 32'(cnt2));
  endtask

  task automatic advance();
    bit s;
    s = m_stall();
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = (s || cur_fl) ? I(0, 0, 0, 0, 0, 0, 0) : cur;
    if (s) begin
      if (cnt16 < 65535) cnt16++;
      if (cnt2 < 3) cnt2++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    ins_t nop, lw8, r;
    nop = I(0, 0, 0, 0, 0, 0, 0);
    lw8 = I(1, 1, 8, 0, 1, 1, 8);
    tbl.push_back(V(I(1, 1, 2, 1, 1, 0, 3), 0, 0, 0, 0, 0));
    tbl.push_back(V(I(1, 3, 5, 1, 1, 0, 4), 0, 0, 0, 0, 0));
    tbl.push_back(V(nop, 0, 1, 0, 0, 0));
    tbl.push_back(V(I(1, 1, 2, 1, 1, 0, 3), 0, 0, 0, 0, 0));
    tbl.push_back(V(nop, 0, 0, 0, 0, 0));
    tbl.push_back(V(I(1, 7, 3, 1, 1, 0, 6), 0, 0, 0, 0, 0));
    tbl.push_back(V(nop, 0, 0, 2, 0, 0));
    tbl.push_back(V(I(1, 1, 2, 1, 1, 0, 3), 0, 0, 0, 0, 0));
    tbl.push_back(V(I(1, 1, 2, 1, 1, 0, 3), 0, 0, 0, 0, 0));
    tbl.push_back(V(I(1, 3, 0, 1, 1, 0, 10), 0, 0, 0, 0, 0));
    tbl.push_back(V(nop, 0, 1, 0, 0, 0));
    tbl.push_back(V(lw8, 0, 0, 0, 0, 0));
    tbl.push_back(V(I(1, 8, 9, 1, 1, 0, 11), 0, 0, 0, 1, 0));
    tbl.push_back(V(I(1, 8, 9, 1, 1, 0, 11), 0, 0, 0, 0, 1));
    tbl.push_back(V(nop, 0, 2, 0, 0, 1));
    tbl.push_back(V(I(1, 1, 2, 1, 1, 0, 0), 0, 0, 0, 0, 1));
    tbl.push_back(V(I(1, 0, 0, 1, 1, 0, 12), 0, 0, 0, 0, 1));
    tbl.push_back(V(I(1, 1, 0, 0, 1, 1, 0), 0, 0, 0, 0, 1));
    tbl.push_back(V(I(1, 0, 0, 1, 1, 0, 13), 0, 0, 0, 0, 1));
    tbl.push_back(V(lw8, 0, 0, 0, 0, 1));
    tbl.push_back(V(I(0, 8, 8, 1, 1, 0, 14), 0, 0, 0, 0, 1));
    tbl.push_back(V(lw8, 0, 0, 0, 0, 1));
    tbl.push_back(V(I(1, 8, 9, 1, 1, 0, 14), 1, 0, 0, 0, 1));
    tbl.push_back(V(nop, 0, 0, 0, 0, 1));

    rst = 1;
    m_reset();
    drive(nop, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_fwd_a", 32'(bus.fwd_a_sel), 0);
    chk("reset_stall_count", 32'(bus.stall_count), 0);
    rst = 0;

    foreach (tbl[n]) begin
      drive(tbl[n].i, tbl[n].fl);
      chk($sformatf("tbl%0d_fwd_a", n), 32'(bus.fwd_a_sel), 32'(tbl[n].ea));
      chk($sformatf("tbl%0d_fwd_b", n), 32'(bus.fwd_b_sel), 32'(tbl[n].eb));
      chk($sformatf("tbl%0d_stall", n), 32'(bus.stall), 32'(tbl[n].es));
      chk($sformatf("tbl%0d_count", n), 32'(bus.stall_count), 32'(tbl[n].ec));
      check_model();
      advance();
    end

    // a load that depends on the previous load stalls every other cycle
    for (int c = 0; c < 11; c++) begin
      drive(I(1, 8, 8, 0, 1, 1, 8), 0);
      check_model();
      advance();
    end
    drive(nop, 0);
    chk("sat_cnt2", 32'(bus2.stall_count), 3);
    chk("sat_cnt16", 32'(bus.stall_count), 6);
    advance();

    drive(I(1, 1, 2, 1, 1, 0, 3), 0);
    advance();
    drive(I(1, 3, 5, 1, 1, 0, 4), 0);
    advance();
    drive(I(1, 3, 3, 1, 1, 0, 5), 0);
    chk("pre_reset_fwd_a", 32'(bus.fwd_a_sel), 1);
    rst = 1;
    m_reset();
    #1;
    chk("async_reset_fwd_a", 32'(bus.fwd_a_sel), 0);
    chk("async_reset_fwd_b", 32'(bus.fwd_b_sel), 0);
    chk("async_reset_stall", 32'(bus.stall), 0);
    chk("async_reset_count", 32'(bus.stall_count), 0);
    chk("async_reset_count2", 32'(bus2.stall_count), 0);
    @(posedge clk);
    #1;
    rst = 0;
    drive(I(1, 3, 3, 1, 1, 0, 7), 0);
    advance();
    drive(nop, 0);
    chk("post_reset_fwd_a", 32'(bus.fwd_a_sel), 0);
    chk("post_reset_fwd_b", 32'(bus.fwd_b_sel), 0);
    check_model();
    advance();

    for (int c = 0; c < 2000; c++) begin
      r.v = ($urandom % 8) != 0;
      r.rs = $urandom_range(0, 3);
      r.rt = $urandom_range(0, 3);
      r.ut = $urandom % 2;
      r.rw = ($urandom % 4) != 0;
      r.mr = ($urandom % 3) == 0;
      r.d = $urandom_range(0, 3);
      drive(r, ($urandom % 10) == 0);
      check_model();
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
